// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle for seq_restoring_divider.
// master: the requester (drives start and operands, reads results).
// slave : the divider itself.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// For any operands: quotient*divisor + remainder == dividend.
// A start seen in IDLE captures the operands; WIDTH edges later the
// results are loaded and done pulses for one cycle, then back to IDLE.
// Optional feature, macro DIV_ZERO_CHECK_EN: a zero divisor takes a short
// ZCHK path (2 edges) returning quotient=all ones, remainder=dividend and
// div_by_zero=1. Without the macro a zero divisor runs the normal loop,
// which naturally yields the same quotient/remainder, and div_by_zero is 0.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  // Counter wide enough to hold WIDTH-1 (and at least one bit).
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef DIV_ZERO_CHECK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ZCHK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  state_t state_reg;
  state_t state_next;

  // Working registers of the iteration.
  logic [WIDTH:0]   rem_acc_reg;   // partial remainder; top bit stays 0 between steps
  logic [WIDTH-1:0] q_sh_reg;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_reg;      // captured divisor
  logic [CW-1:0]    cnt_reg;       // iterations left after the current one

  // Registered outputs.
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  // One restoring step, computed combinationally from the working registers.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic             last_iter;
  logic             divisor_zero;

  assign last_iter    = (cnt_reg == '0);
  assign divisor_zero = (bus.divisor == '0);

  // Shift the next dividend bit into the remainder and try the subtraction;
  // a borrow (trial MSB set) means the divisor did not fit, so restore.
  always_comb begin
    partial  = (rem_acc_reg << 1) | {{WIDTH{1'b0}}, q_sh_reg[WIDTH-1]};
    trial    = partial - {1'b0, dvsr_reg};
    rem_step = partial;
    q_step   = {q_sh_reg[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_step = trial;
      q_step   = {q_sh_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor_zero) begin
            state_next = ZCHK;
          end
`endif
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
`ifdef DIV_ZERO_CHECK_EN
      ZCHK: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture and one iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_acc_reg <= '0;
      q_sh_reg    <= '0;
      dvsr_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dvsr_reg    <= bus.divisor;
            q_sh_reg    <= bus.dividend;
            rem_acc_reg <= '0;
            cnt_reg     <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
            // ZCHK reuses the counter to span its two cycles.
            if (divisor_zero) begin
              cnt_reg <= CW'(1);
            end
`endif
          end
        end
        RUN: begin
          rem_acc_reg <= rem_step;
          q_sh_reg    <= q_step;
          cnt_reg     <= cnt_reg - CW'(1);
        end
`ifdef DIV_ZERO_CHECK_EN
        ZCHK: begin
          cnt_reg <= cnt_reg - CW'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Status flags follow the state being entered, so they are registered
  // yet line up exactly with RUN/ZCHK and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
`ifdef DIV_ZERO_CHECK_EN
      busy_reg <= (state_next == RUN) || (state_next == ZCHK);
`else
      busy_reg <= (state_next == RUN);
`endif
      done_reg <= (state_next == DONE);
    end
  end

  // Result registers load on the final step and hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if ((state_reg == RUN) && last_iter) begin
      quotient_reg  <= q_step;
      remainder_reg <= rem_step[WIDTH-1:0];
    end
`ifdef DIV_ZERO_CHECK_EN
    else if ((state_reg == ZCHK) && last_iter) begin
      // q_sh_reg still holds the untouched dividend on this path.
      quotient_reg  <= '1;
      remainder_reg <= q_sh_reg;
    end
`endif
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_reg;

  // Divide-by-zero flag is updated together with the results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_reg <= 1'b0;
    end else if ((state_reg == RUN) && last_iter) begin
      dbz_reg <= 1'b0;
    end else if ((state_reg == ZCHK) && last_iter) begin
      dbz_reg <= 1'b1;
    end
  end

  assign bus.div_by_zero = dbz_reg;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider (WIDTH=4): directed cases, start
// interference, asynchronous abort, exhaustive operand sweep and a random
// start/operand stream, all checked by a per-cycle reference model.
`timescale 1ns/1ps
module tb_seq_restoring_divider;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected result of one division, from plain arithmetic.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r,
                                  output int dz, output int lat);
    if (b == 0) begin
      q = MAXV;
      r = a;
`ifdef DIV_ZERO_CHECK_EN
      dz  = 1;
      lat = 2;
`else
      dz  = 0;
      lat = W;
`endif
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 0;
      lat = W;
    end
  endfunction

  // Timing model: edges are numbered from reset release. A start is taken
  // only once the previous DONE cycle has passed; busy covers the lat
  // cycles after acceptance, done the single cycle after that.
  int edge_n    = 0;
  int acc_edge  = -10;
  int done_edge = -10;
  int free_edge = 0;
  int pq = 0, pr = 0, pdz = 0;
  int mq = 0, mr = 0, mdz = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n    = 0;
      acc_edge  = -10;
      done_edge = -10;
      free_edge = 0;
      mq = 0; mr = 0; mdz = 0;
    end else begin
      int lat;
      edge_n++;
      if (edge_n == done_edge) begin
        mq = pq; mr = pr; mdz = pdz;
      end
      if (bus.start && edge_n >= free_edge) begin
        ref_div(int'(bus.dividend), int'(bus.divisor), pq, pr, pdz, lat);
        acc_edge  = edge_n;
        done_edge = edge_n + lat;
        free_edge = edge_n + lat + 2;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(edge_n >= acc_edge && edge_n < done_edge));
    chk("done", 32'(bus.done), 32'(edge_n == done_edge));
    chk("quotient", 32'(bus.quotient), 32'(mq));
    chk("remainder", 32'(bus.remainder), 32'(mr));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(mdz));
  end

  // One handshake: pulse start, scramble operands afterwards, wait for done.
  task automatic do_div(input int a, input int b,
                        output int q, output int r, output int dz,
                        output int lat, output int bc);
    int k;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom_range(MAXV, 0));
    bus.divisor  = W'($urandom_range(MAXV, 0));
    k  = 0;
    bc = 0;
    while (!bus.done && k < 20) begin
      if (bus.busy) bc++;
      @(negedge clk);
      k++;
    end
    chk($sformatf("done_seen %0d/%0d", a, b), 32'(bus.done), 32'd1);
    lat = k;
    q   = int'(bus.quotient);
    r   = int'(bus.remainder);
    dz  = int'(bus.div_by_zero);
  endtask

  // Directed case with hand-computed expectations.
  task automatic run_case(input int a, input int b, input int eq, input int er,
                          input int edz, input int elat);
    int q, r, dz, lat, bc;
    do_div(a, b, q, r, dz, lat, bc);
    chk($sformatf("q %0d/%0d", a, b), 32'(q), 32'(eq));
    chk($sformatf("r %0d/%0d", a, b), 32'(r), 32'(er));
    chk($sformatf("dbz %0d/%0d", a, b), 32'(dz), 32'(edz));
    chk($sformatf("latency %0d/%0d", a, b), 32'(lat), 32'(elat));
    chk($sformatf("busy_cycles %0d/%0d", a, b), 32'(bc), 32'(elat));
  endtask

  initial begin
    int q, r, dz, lat, bc, k, dones;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    // Directed cases, issued back-to-back
    run_case(13, 3, 4, 1, 0, 4);
    run_case(15, 1, 15, 0, 0, 4);
    run_case(2, 7, 0, 2, 0, 4);
    run_case(0, 5, 0, 0, 0, 4);
    run_case(15, 15, 1, 0, 0, 4);
`ifdef DIV_ZERO_CHECK_EN
    run_case(9, 0, 15, 9, 1, 2);
`else
    run_case(9, 0, 15, 9, 0, 4);
`endif

    // Start and new operands pulsed while 13/3 is running
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = W'(13); bus.divisor = W'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = W'($urandom_range(MAXV, 0));
      bus.divisor  = W'($urandom_range(MAXV, 1));
    end
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("interfere_done", 32'(bus.done), 32'd1);
    chk("interfere_q", 32'(bus.quotient), 32'd4);
    chk("interfere_r", 32'(bus.remainder), 32'd1);
    // Start on the cycle right after done must be taken
    run_case(7, 2, 3, 1, 0, 4);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = W'(13); bus.divisor = W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    chk("abort_r", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Every operand pair with a nonzero divisor
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 1; b <= MAXV; b++) begin
        do_div(a, b, q, r, dz, lat, bc);
        chk($sformatf("identity %0d/%0d", a, b), 32'(q * b + r), 32'(a));
        chk($sformatf("rem_lt_div %0d/%0d", a, b), 32'(r < b), 32'd1);
      end
    end

    // Dividing 2x2 products by one factor returns the other
    for (int a = 0; a < 4; a++) begin
      for (int b = 1; b < 4; b++) begin
        do_div(a * b, b, q, r, dz, lat, bc);
        chk($sformatf("product_q %0d*%0d", a, b), 32'(q), 32'(a));
        chk($sformatf("product_r %0d*%0d", a, b), 32'(r), 32'd0);
      end
    end

    // Random start/operand stream; the model decides what is accepted
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.dividend = W'($urandom_range(MAXV, 0));
      bus.divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(MAXV, 0));
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
